// File: rtl/regwr_pkg.sv
// rtl/regwr_pkg.sv - shared constants, request struct and round-robin helper for regwr_arbiter
package regwr_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = $clog2(DATA_W);
    localparam int REG_ZERO = 0;
    // Wide enough for any legal requester count (2..8).
    localparam int PTR_W    = 4;

    typedef struct packed {
        logic [ADDR_W-1:0] wnum;
        logic [DATA_W-1:0] wdata;
    } regwr_req_t;

    // Advance a round-robin pointer by one, wrapping from n-1 to 0.
    function automatic logic [PTR_W-1:0] rr_next(input logic [PTR_W-1:0] ptr,
                                                 input logic [PTR_W-1:0] n);
        logic [PTR_W-1:0] inc;
        inc = ptr + PTR_W'(1);
        return (inc >= n) ? '0 : inc;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker
//
// Purpose: find the first set bit of req_i, searching upward from ptr_i and wrapping
// modulo N.
// Ports:
//   req_i   [N]   request vector
//   ptr_i   [IW]  search start (highest-priority index), must be < N
//   grant_o [N]   one-hot grant, zero when no request
//   idx_o   [IW]  encoded winner, zero when no request
//   any_o   [1]   at least one request present
module rr_pick
    import regwr_pkg::*;
#(
    parameter int N  = 3,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    // Rotate so that the pointer position lands at bit 0; the lowest set bit of
    // rot is then the winner's offset from the pointer.
    logic [2*N-1:0] req2;
    logic [N-1:0]   rot;
    logic [IW:0]    sum;

    always_comb begin
        req2    = {req_i, req_i};
        rot     = N'(req2 >> ptr_i);
        any_o   = 1'b0;
        sum     = '0;
        grant_o = '0;
        for (int k = 0; k < N; k++) begin
            if (!any_o && rot[k]) begin
                any_o = 1'b1;
                sum   = {1'b0, ptr_i} + (IW+1)'(k);
            end
        end
        if (sum >= (IW+1)'(N)) begin
            sum = sum - (IW+1)'(N);
        end
        idx_o = sum[IW-1:0];
        if (any_o) begin
            grant_o[idx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/regwr_arbiter.sv
// rtl/regwr_arbiter.sv - round-robin arbiter for the single register-file write port
//
// Purpose: share write/wnum/wdata between NUM_REQ writeback requesters using
// valid/ready handshakes; the winner is registered and drives the register file one
// cycle later. Writes to register 0 complete the handshake but leave write low.
// Optional feature macro: REGWR_BYPASS_EN (adds read-forwarding compare ports).
// Ports:
//   clk, rst (sync, active-low)
//   stall                     grant nothing this cycle
//   req_valid/req_wnum/req_wdata  packed per-requester requests
//   req_ready                 one-hot combinational grant
//   write/wnum/wdata          registered register-file write port
//   grant_idx                 last granted requester (debug)
//   rnum1/rnum2, byp*_hit, byp*_data  forwarding compare (REGWR_BYPASS_EN only)
module regwr_arbiter
    import regwr_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int NUM_REQ = 3,
    localparam int ADDR_WIDTH = $clog2(WIDTH),
    localparam int IDX_W      = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          stall,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_wnum,
    input  logic [NUM_REQ*WIDTH-1:0]      req_wdata,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          write,
    output logic [ADDR_WIDTH-1:0]         wnum,
    output logic [WIDTH-1:0]              wdata,
`ifdef REGWR_BYPASS_EN
    input  logic [ADDR_WIDTH-1:0]         rnum1,
    input  logic [ADDR_WIDTH-1:0]         rnum2,
    output logic                          byp1_hit,
    output logic                          byp2_hit,
    output logic [WIDTH-1:0]              byp1_data,
    output logic [WIDTH-1:0]              byp2_data,
`endif
    output logic [IDX_W-1:0]              grant_idx
);

    logic [IDX_W-1:0]      ptr_q, ptr_d;
    logic                  write_q, write_d;
    logic [ADDR_WIDTH-1:0] wnum_q, wnum_d;
    logic [WIDTH-1:0]      wdata_q, wdata_d;
    logic [IDX_W-1:0]      gidx_q, gidx_d;

    logic [NUM_REQ-1:0]    req_masked;
    logic [NUM_REQ-1:0]    pick_grant;
    logic [IDX_W-1:0]      pick_idx;
    logic                  pick_any;
    logic [ADDR_WIDTH-1:0] win_wnum;
    logic [WIDTH-1:0]      win_wdata;

    // Masking requests (not the grant) keeps ready independent of wnum/wdata and
    // guarantees no transfer while in reset or stalled.
    assign req_masked = (rst && !stall) ? req_valid : '0;

    rr_pick #(
        .N  (NUM_REQ),
        .IW (IDX_W)
    ) u_pick (
        .req_i   (req_masked),
        .ptr_i   (ptr_q),
        .grant_o (pick_grant),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

    assign req_ready = pick_grant;

    always_comb begin
        win_wnum  = '0;
        win_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_grant[i]) begin
                win_wnum  = req_wnum[i*ADDR_WIDTH +: ADDR_WIDTH];
                win_wdata = req_wdata[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        ptr_d   = ptr_q;
        write_d = 1'b0;
        wnum_d  = wnum_q;
        wdata_d = wdata_q;
        gidx_d  = gidx_q;
        if (pick_any) begin
            write_d = (win_wnum != ADDR_WIDTH'(REG_ZERO));
            wnum_d  = win_wnum;
            wdata_d = win_wdata;
            gidx_d  = pick_idx;
            ptr_d   = IDX_W'(rr_next(PTR_W'(pick_idx), PTR_W'(NUM_REQ)));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr_q   <= '0;
            write_q <= 1'b0;
            wnum_q  <= '0;
            wdata_q <= '0;
            gidx_q  <= '0;
        end else begin
            ptr_q   <= ptr_d;
            write_q <= write_d;
            wnum_q  <= wnum_d;
            wdata_q <= wdata_d;
            gidx_q  <= gidx_d;
        end
    end

    assign write     = write_q;
    assign wnum      = wnum_q;
    assign wdata     = wdata_q;
    assign grant_idx = gidx_q;

`ifdef REGWR_BYPASS_EN
    // Same-cycle forwarding of the write the register file is committing now.
    assign byp1_hit  = write_q && (rnum1 == wnum_q) && (rnum1 != ADDR_WIDTH'(REG_ZERO));
    assign byp2_hit  = write_q && (rnum2 == wnum_q) && (rnum2 != ADDR_WIDTH'(REG_ZERO));
    assign byp1_data = wdata_q;
    assign byp2_data = wdata_q;
`endif

endmodule

// File: tb/tb_regwr_arbiter.sv
// tb/tb_regwr_arbiter.sv - self-checking testbench for regwr_arbiter
module tb_regwr_arbiter;
    import regwr_pkg::*;

    localparam int WIDTH   = 32;
    localparam int NUM_REQ = 3;
    localparam int AW      = $clog2(WIDTH);
    localparam int IW      = $clog2(NUM_REQ);

    logic                     clk = 1'b0;
    logic                     rst = 1'b0;
    logic                     stall = 1'b0;
    logic [NUM_REQ-1:0]       req_valid = '0;
    logic [NUM_REQ*AW-1:0]    req_wnum;
    logic [NUM_REQ*WIDTH-1:0] req_wdata;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     write;
    logic [AW-1:0]            wnum;
    logic [WIDTH-1:0]         wdata;
    logic [IW-1:0]            grant_idx;
`ifdef REGWR_BYPASS_EN
    logic [AW-1:0]            rnum1 = '0;
    logic [AW-1:0]            rnum2 = '0;
    logic                     byp1_hit, byp2_hit;
    logic [WIDTH-1:0]         byp1_data, byp2_data;
`endif

    regwr_req_t r_req [NUM_REQ];

    always_comb begin
        req_wnum  = '0;
        req_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_wnum[i*AW +: AW]        = r_req[i].wnum;
            req_wdata[i*WIDTH +: WIDTH] = r_req[i].wdata;
        end
    end

    regwr_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .req_valid (req_valid),
        .req_wnum  (req_wnum),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .write     (write),
        .wnum      (wnum),
        .wdata     (wdata),
`ifdef REGWR_BYPASS_EN
        .rnum1     (rnum1),
        .rnum2     (rnum2),
        .byp1_hit  (byp1_hit),
        .byp2_hit  (byp2_hit),
        .byp1_data (byp1_data),
        .byp2_data (byp2_data),
`endif
        .grant_idx (grant_idx)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: pointer as a plain integer, expected register-file outputs.
    int               m_ptr   = 0;
    logic             m_write = 1'b0;
    logic [AW-1:0]    m_wnum  = '0;
    logic [WIDTH-1:0] m_wdata = '0;
    logic [IW-1:0]    m_gidx  = '0;

    function automatic int model_winner();
        if (!rst || stall) return -1;
        for (int k = 0; k < NUM_REQ; k++) begin
            int i;
            i = (m_ptr + k) % NUM_REQ;
            if (req_valid[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [NUM_REQ-1:0] model_ready();
        int w;
        w = model_winner();
        if (w < 0) return '0;
        return NUM_REQ'(1) << w;
    endfunction

    task automatic tick();
        int w;
        w = model_winner();
        if (!rst) begin
            m_ptr = 0; m_write = 1'b0; m_wnum = '0; m_wdata = '0; m_gidx = '0;
        end else if (w >= 0) begin
            m_write = (r_req[w].wnum != 0);
            m_wnum  = r_req[w].wnum;
            m_wdata = r_req[w].wdata;
            m_gidx  = IW'(w);
            m_ptr   = (w + 1) % NUM_REQ;
        end else begin
            m_write = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        stall = 1'b0;
        req_valid = '1;
        r_req[0] = '{wnum: 5'd1, wdata: 32'hA};
        r_req[1] = '{wnum: 5'd2, wdata: 32'hB};
        r_req[2] = '{wnum: 5'd3, wdata: 32'hC};
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (req_ready !== 3'b000) begin
                errors++;
                $display("FAIL reset_ready cycle %0d: got %b want 000", c, req_ready);
            end
            tick();
            checks++;
            if (write !== 1'b0 || wnum !== '0 || wdata !== '0 || grant_idx !== '0) begin
                errors++;
                $display("FAIL reset_outputs cycle %0d: got w=%b n=%0d d=%h g=%0d want all zero",
                         c, write, wnum, wdata, grant_idx);
            end
        end
        rst = 1'b1;
        #1;
        checks++;
        if (req_ready !== 3'b001) begin
            errors++;
            $display("FAIL reset_first_grant: got %b want 001", req_ready);
        end
    endtask

    task automatic test_round_robin();
        for (int k = 0; k < 6; k++) begin
            int e;
            e = k % NUM_REQ;
            #1;
            checks++;
            if (req_ready !== (3'b001 << e)) begin
                errors++;
                $display("FAIL rr_ready step %0d: got %b want %b", k, req_ready, 3'b001 << e);
            end
            tick();
            checks++;
            if (write !== 1'b1 || wnum !== AW'(e + 1) || wdata !== WIDTH'(32'hA + e)
                || grant_idx !== IW'(e)) begin
                errors++;
                $display("FAIL rr_write step %0d: got w=%b n=%0d d=%h g=%0d want w=1 n=%0d d=%h g=%0d",
                         k, write, wnum, wdata, grant_idx, e + 1, 32'hA + e, e);
            end
        end
    endtask

    task automatic test_zero_reg();
        req_valid = 3'b010;
        r_req[1] = '{wnum: 5'd0, wdata: 32'hDEAD};
        #1;
        checks++;
        if (req_ready !== 3'b010) begin
            errors++;
            $display("FAIL zero_ready: got %b want 010", req_ready);
        end
        tick();
        checks++;
        if (write !== 1'b0 || wnum !== 5'd0 || wdata !== 32'hDEAD || grant_idx !== 2'd1) begin
            errors++;
            $display("FAIL zero_write: got w=%b n=%0d d=%h g=%0d want w=0 n=0 d=dead g=1",
                     write, wnum, wdata, grant_idx);
        end
        r_req[1] = '{wnum: 5'd2, wdata: 32'hB};
        req_valid = 3'b111;
        #1;
        checks++;
        if (req_ready !== 3'b100) begin
            errors++;
            $display("FAIL zero_ptr_advance: got %b want 100", req_ready);
        end
        tick();
        checks++;
        if (write !== 1'b1 || wnum !== 5'd3 || wdata !== 32'hC) begin
            errors++;
            $display("FAIL zero_next_write: got w=%b n=%0d d=%h want w=1 n=3 d=c", write, wnum, wdata);
        end
    endtask

    task automatic test_stall();
        req_valid = 3'b111;
        stall = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++;
            if (req_ready !== 3'b000) begin
                errors++;
                $display("FAIL stall_ready cycle %0d: got %b want 000", c, req_ready);
            end
            tick();
            checks++;
            if (write !== 1'b0 || wnum !== 5'd3 || grant_idx !== 2'd2) begin
                errors++;
                $display("FAIL stall_hold cycle %0d: got w=%b n=%0d g=%0d want w=0 n=3 g=2",
                         c, write, wnum, grant_idx);
            end
        end
        stall = 1'b0;
        #1;
        checks++;
        if (req_ready !== 3'b001) begin
            errors++;
            $display("FAIL stall_resume: got %b want 001", req_ready);
        end
        tick();
        checks++;
        if (write !== 1'b1 || wnum !== 5'd1) begin
            errors++;
            $display("FAIL stall_resume_write: got w=%b n=%0d want w=1 n=1", write, wnum);
        end
    endtask

    task automatic test_fairness();
        logic granted;
        req_valid = 3'b001;
        r_req[0] = '{wnum: 5'd7, wdata: 32'h0F0F_0001};
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if (req_ready !== 3'b001) begin
                errors++;
                $display("FAIL single_ready cycle %0d: got %b want 001", c, req_ready);
            end
            tick();
            checks++;
            if (write !== 1'b1 || wnum !== 5'd7 || wdata !== 32'h0F0F_0001) begin
                errors++;
                $display("FAIL single_write cycle %0d: got w=%b n=%0d d=%h want w=1 n=7 d=0f0f0001",
                         c, write, wnum, wdata);
            end
        end
        r_req[2] = '{wnum: 5'd9, wdata: 32'h2222};
        req_valid = 3'b101;
        granted = 1'b0;
        for (int c = 0; c < NUM_REQ && !granted; c++) begin
            #1;
            granted = req_ready[2];
            tick();
        end
        checks++;
        if (!granted || wnum !== 5'd9 || wdata !== 32'h2222) begin
            errors++;
            $display("FAIL fair_grant: got granted=%b n=%0d d=%h want granted=1 n=9 d=2222 within %0d",
                     granted, wnum, wdata, NUM_REQ);
        end
        req_valid = 3'b001;
        #1;
        tick();
        checks++;
        if (write !== 1'b1 || wdata !== 32'h0F0F_0001) begin
            errors++;
            $display("FAIL fair_hold_data: got w=%b d=%h want w=1 d=0f0f0001", write, wdata);
        end
    endtask

    task automatic test_random();
        logic [NUM_REQ-1:0] pend;
        pend = '0;
        for (int c = 0; c < 300; c++) begin
            int w;
            logic [NUM_REQ-1:0] exp_ready;
            rst   = ($urandom_range(0, 39) != 0);
            stall = ($urandom_range(0, 7) == 0);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1) begin
                    pend[i] = 1'b1;
                    r_req[i].wnum  = ($urandom_range(0, 5) == 0) ? 5'd0 : AW'($urandom);
                    r_req[i].wdata = $urandom;
                end
            end
            req_valid = pend;
            #1;
            exp_ready = model_ready();
            checks++;
            if (req_ready !== exp_ready) begin
                errors++;
                $display("FAIL rand_ready cycle %0d: got %b want %b", c, req_ready, exp_ready);
            end
            w = model_winner();
            tick();
            if (w >= 0) pend[w] = 1'b0;
            checks++;
            if (write !== m_write || wnum !== m_wnum || wdata !== m_wdata || grant_idx !== m_gidx) begin
                errors++;
                $display("FAIL rand_out cycle %0d: got w=%b n=%0d d=%h g=%0d want w=%b n=%0d d=%h g=%0d",
                         c, write, wnum, wdata, grant_idx, m_write, m_wnum, m_wdata, m_gidx);
            end
        end
        rst = 1'b1;
        stall = 1'b0;
        req_valid = '0;
        #1;
        tick();
    endtask

`ifdef REGWR_BYPASS_EN
    task automatic test_bypass();
        req_valid = 3'b001;
        r_req[0] = '{wnum: 5'd3, wdata: 32'h1234};
        #1;
        tick();
        req_valid = '0;
        rnum1 = 5'd3;
        rnum2 = 5'd0;
        #1;
        checks++;
        if (byp1_hit !== 1'b1 || byp1_data !== 32'h1234 || byp2_hit !== 1'b0) begin
            errors++;
            $display("FAIL bypass: got h1=%b d1=%h h2=%b want h1=1 d1=1234 h2=0",
                     byp1_hit, byp1_data, byp2_hit);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_round_robin();
        test_zero_reg();
        test_stall();
        test_fairness();
        test_random();
`ifdef REGWR_BYPASS_EN
        test_bypass();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
